// File: rtl/trace_checker.sv
// Checks a processor fetch stream against a preloaded table of expected PCs and optional opcodes.
// Compare results appear on the outputs one cycle after each fetch. There is no backpressure; a fetch that arrives outside RUN is dropped.
module trace_checker #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 64,
    parameter int TIMEOUT      = 1024,
    parameter int STOP_ON_FAIL = 0,
    parameter int CNT_W        = 8,
    localparam int IDX_W       = $clog2(DEPTH),
    localparam int ENT_W       = ADDR_W + DATA_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W:0]    exp_len,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_waddr,
    input  logic [ENT_W-1:0]  exp_wdata,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic [DATA_W-1:0] fetch_opcode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [IDX_W-1:0]  first_bad_idx,
    output logic [ADDR_W-1:0] first_bad_pc
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t            state;
    logic [ENT_W-1:0]  exp_mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  last_idx;
    logic [TW-1:0]     idle_cnt;

    logic [ENT_W-1:0]  cur;
    logic              pc_bad;
    logic              op_bad;
    logic              mism;
    logic [IDX_W:0]    len_clamped;
    logic [IDX_W:0]    len_m1;

    // Table has no reset; it is loaded by software before each run.
    always_ff @(posedge clk) begin
        if (exp_we && state != RUN) begin
            exp_mem[exp_waddr] <= exp_wdata;
        end
    end

    assign cur         = exp_mem[idx];
    assign pc_bad      = fetch_pc != cur[ADDR_W+DATA_W-1:DATA_W];
    assign op_bad      = cur[ENT_W-1] && (fetch_opcode != cur[DATA_W-1:0]);
    assign mism        = pc_bad || op_bad;
    assign len_clamped = (exp_len > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : exp_len;
    assign len_m1      = len_clamped - (IDX_W+1)'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            mismatch_count <= '0;
            first_bad_idx  <= '0;
            first_bad_pc   <= '0;
            idx            <= '0;
            last_idx       <= '0;
            idle_cnt       <= '0;
        end else begin
            case (state)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        idx            <= '0;
                        idle_cnt       <= '0;
                        mismatch_count <= '0;
                        first_bad_idx  <= '0;
                        first_bad_pc   <= '0;
                        timeout        <= 1'b0;
                        fail           <= 1'b0;
                        last_idx       <= len_m1[IDX_W-1:0];
                        if (len_clamped == '0) begin
                            state <= PASS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (fetch_valid) begin
                        idle_cnt <= '0;
                        idx      <= idx + IDX_W'(1);
                        if (mism) begin
                            if (mismatch_count != '1) begin
                                mismatch_count <= mismatch_count + CNT_W'(1);
                            end
                            if (mismatch_count == '0) begin
                                first_bad_idx <= idx;
                                first_bad_pc  <= fetch_pc;
                            end
                        end
                        if (mism && STOP_ON_FAIL != 0) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            fail  <= 1'b1;
                        end else if (idx == last_idx) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            // Verdict must include this fetch's result, not just the registered count.
                            if (mismatch_count == '0 && !mism) begin
                                state <= PASS;
                                pass  <= 1'b1;
                            end else begin
                                state <= FAIL;
                                fail  <= 1'b1;
                            end
                        end
                    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        state   <= FAIL;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: one instance runs to the end of the trace, the other stops on the first mismatch.
module tb_trace_checker;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DEP = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [IW:0]   exp_len = '0;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_waddr = '0;
    logic [AW+DW:0] exp_wdata = '0;
    logic          fetch_valid = 1'b0;
    logic [AW-1:0] fetch_pc = '0;
    logic [DW-1:0] fetch_opcode = '0;

    logic          busy0, done0, pass0, fail0, tmo0;
    logic [7:0]    cnt0;
    logic [IW-1:0] bidx0;
    logic [AW-1:0] bpc0;
    logic          busy1, done1, pass1, fail1, tmo1;
    logic [7:0]    cnt1;
    logic [IW-1:0] bidx1;
    logic [AW-1:0] bpc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trace_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .TIMEOUT(16), .STOP_ON_FAIL(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .exp_len(exp_len),
        .exp_we(exp_we), .exp_waddr(exp_waddr), .exp_wdata(exp_wdata),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_opcode(fetch_opcode),
        .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .timeout(tmo0),
        .mismatch_count(cnt0), .first_bad_idx(bidx0), .first_bad_pc(bpc0));

    trace_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .TIMEOUT(16), .STOP_ON_FAIL(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .exp_len(exp_len),
        .exp_we(exp_we), .exp_waddr(exp_waddr), .exp_wdata(exp_wdata),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_opcode(fetch_opcode),
        .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .timeout(tmo1),
        .mismatch_count(cnt1), .first_bad_idx(bidx1), .first_bad_pc(bpc1));

    typedef struct {
        int          gap;
        logic [15:0] pc;
        logic [7:0]  op;
        logic        busy_e;
        logic [7:0]  cnt_e;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic en, input logic [15:0] pc, input logic [7:0] op);
        exp_waddr = IW'(a);
        exp_wdata = {en, pc, op};
        exp_we = 1'b1;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic do_start(input int len);
        exp_len = (IW+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [7:0] op);
        fetch_pc = pc;
        fetch_opcode = op;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_pass"}, pass0, 0);
        chk({tag, "_fail"}, fail0, 0);
        chk({tag, "_timeout"}, tmo0, 0);
        chk({tag, "_count"}, cnt0, 0);
        chk({tag, "_bad_idx"}, bidx0, 0);
        chk({tag, "_bad_pc"}, bpc0, 0);
    endtask

    initial begin
        vecs[0] = '{0, 16'h000C, 8'h11, 1'b1, 8'd0};
        vecs[1] = '{2, 16'h000E, 8'h22, 1'b1, 8'd0};
        vecs[2] = '{1, 16'h0010, 8'h33, 1'b1, 8'd0};
        vecs[3] = '{3, 16'h0013, 8'h44, 1'b0, 8'd0};
        vecs[4] = '{1, 16'h000C, 8'h00, 1'b1, 8'd0};
        vecs[5] = '{0, 16'h000F, 8'h00, 1'b1, 8'd1};
        vecs[6] = '{2, 16'h0010, 8'h00, 1'b1, 8'd1};
        vecs[7] = '{0, 16'h0013, 8'h00, 1'b0, 8'd1};

        #12;
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        load(0, 1'b0, 16'h000C, 8'h00);
        load(1, 1'b0, 16'h000E, 8'h00);
        load(2, 1'b0, 16'h0010, 8'h00);
        load(3, 1'b0, 16'h0013, 8'h00);

        // Run A: all match (pass); run B: second fetch wrong PC.
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) do_start(4);
            repeat (vecs[i].gap) tick();
            fetch(vecs[i].pc, vecs[i].op);
            chk($sformatf("vec%0d_busy", i), busy0, vecs[i].busy_e);
            chk($sformatf("vec%0d_count", i), cnt0, vecs[i].cnt_e);
            if (i == 3) begin
                chk("runA_pass", pass0, 1);
                chk("runA_done", done0, 1);
                chk("runA_fail", fail0, 0);
                chk("runA_stop_pass", pass1, 1);
            end
            if (i == 7) begin
                chk("runB_fail", fail0, 1);
                chk("runB_pass", pass0, 0);
                chk("runB_bad_idx", bidx0, 1);
                chk("runB_bad_pc", bpc0, 16'h000F);
                chk("runB_stop_fail", fail1, 1);
                chk("runB_stop_count", cnt1, 1);
                chk("runB_stop_bad_idx", bidx1, 1);
            end
        end
        repeat (5) tick();
        chk("hold_fail", fail0, 1);
        chk("hold_count", cnt0, 1);
        chk("hold_bad_pc", bpc0, 16'h000F);

        // Opcode check with stop-on-fail.
        load(0, 1'b1, 16'h000C, 8'h8F);
        do_start(4);
        fetch(16'h000C, 8'h00);
        chk("op_stop_fail", fail1, 1);
        chk("op_stop_busy", busy1, 0);
        chk("op_stop_count", cnt1, 1);
        chk("op_run_busy", busy0, 1);
        chk("op_run_count", cnt0, 1);
        fetch(16'h000E, 8'h00);
        fetch(16'h0011, 8'h00);
        fetch(16'h0013, 8'h00);
        chk("op_run_fail", fail0, 1);
        chk("op_run_count_end", cnt0, 2);
        chk("op_run_bad_idx", bidx0, 0);
        chk("op_stop_frozen", cnt1, 1);
        load(0, 1'b0, 16'h000C, 8'h00);

        // Timeout after 16 idle RUN cycles.
        do_start(4);
        repeat (15) tick();
        chk("tmo_pre_busy", busy0, 1);
        chk("tmo_pre_fail", fail0, 0);
        tick();
        chk("tmo_fail", fail0, 1);
        chk("tmo_flag", tmo0, 1);
        chk("tmo_busy", busy0, 0);

        // Fetch on the 16th idle cycle beats the timeout.
        do_start(2);
        chk("tmo_cleared_by_start", tmo0, 0);
        repeat (15) tick();
        fetch(16'h000C, 8'h00);
        chk("late_busy", busy0, 1);
        chk("late_timeout", tmo0, 0);
        chk("late_fail", fail0, 0);
        fetch(16'h000E, 8'h00);
        chk("late_pass", pass0, 1);

        // Zero-length run.
        do_start(0);
        chk("len0_pass", pass0, 1);
        chk("len0_busy", busy0, 0);

        // Length clamp to DEPTH; table writes during RUN ignored.
        load(4, 1'b0, 16'h0020, 8'h00);
        load(5, 1'b0, 16'h0021, 8'h00);
        load(6, 1'b0, 16'h0022, 8'h00);
        load(7, 1'b0, 16'h0023, 8'h00);
        do_start(15);
        exp_waddr = 3'd5;
        exp_wdata = {1'b0, 16'hFFFF, 8'h00};
        exp_we = 1'b1;
        fetch(16'h000C, 8'h00);
        exp_we = 1'b0;
        fetch(16'h000E, 8'h00);
        fetch(16'h0010, 8'h00);
        fetch(16'h0013, 8'h00);
        fetch(16'h0020, 8'h00);
        fetch(16'h0021, 8'h00);
        fetch(16'h0022, 8'h00);
        chk("clamp_busy7", busy0, 1);
        fetch(16'h0023, 8'h00);
        chk("clamp_pass", pass0, 1);
        chk("clamp_count", cnt0, 0);

        // Start during RUN ignored, then asynchronous reset mid-run.
        do_start(4);
        fetch(16'h000C, 8'h00);
        exp_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy0, 1);
        chk("restart_pass", pass0, 0);
        fetch(16'h0099, 8'h00);
        chk("restart_bad_idx", bidx0, 1);
        chk("restart_count", cnt0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        reset_n = 1'b1;
        repeat (3) tick();
        fetch(16'h0055, 8'h00);
        chk("idle_busy", busy0, 0);
        chk("idle_done", done0, 0);
        chk("idle_count", cnt0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
